// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction queue between fetch and decode with wrong-path flush
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_flush,
    input  logic              io_in_valid,
    input  logic [PC_W-1:0]   io_in_pc,
    input  logic [INST_W-1:0] io_in_inst,
    output logic              io_in_ready,
    output logic              io_out_valid,
    output logic [PC_W-1:0]   io_out_pc,
    output logic [INST_W-1:0] io_out_inst,
    input  logic              io_in_deqReady,
    output logic [CNT_W-1:0]  io_out_count,
    output logic [7:0]        io_out_flushDropCnt
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Pointer/occupancy state; pointers wrap naturally because DEPTH is a power of two
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    // Payload storage, deliberately left unreset
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic not_empty;
    logic enq_fire;
    logic deq_fire;

    // Handshakes and head data; ready depends only on state and flush, never on deqReady
    always_comb begin
        not_empty    = (count_q != '0);
        io_in_ready  = (count_q != FULL_CNT) & ~io_in_flush;
        io_out_valid = not_empty & ~io_in_flush;
        enq_fire     = io_in_valid & io_in_ready;
        deq_fire     = io_out_valid & io_in_deqReady;
        io_out_pc    = not_empty ? pc_mem[head_q]   : '0;
        io_out_inst  = not_empty ? inst_mem[head_q] : '0;
        io_out_count        = count_q;
        io_out_flushDropCnt = drop_cnt_q;
    end

    // Next-state: flush empties the queue and records whether anything was discarded
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        if (io_in_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (not_empty && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else begin
            if (enq_fire) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (deq_fire) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Payload write at the tail on an accepted enqueue
    always_ff @(posedge clock) begin
        if (enq_fire) begin
            pc_mem[tail_q]   <= io_in_pc;
            inst_mem[tail_q] <= io_in_inst;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed vector bench for fetch_queue
module tb_fetch_queue;

    logic        clock;
    logic        reset;
    logic        io_in_flush;
    logic        io_in_valid;
    logic [31:0] io_in_pc;
    logic [31:0] io_in_inst;
    logic        io_in_ready;
    logic        io_out_valid;
    logic [31:0] io_out_pc;
    logic [31:0] io_out_inst;
    logic        io_in_deqReady;
    logic [2:0]  io_out_count;
    logic [7:0]  io_out_flushDropCnt;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_queue #(.DEPTH(4), .PC_W(32), .INST_W(32)) dut (
        .clock               (clock),
        .reset               (reset),
        .io_in_flush         (io_in_flush),
        .io_in_valid         (io_in_valid),
        .io_in_pc            (io_in_pc),
        .io_in_inst          (io_in_inst),
        .io_in_ready         (io_in_ready),
        .io_out_valid        (io_out_valid),
        .io_out_pc           (io_out_pc),
        .io_out_inst         (io_out_inst),
        .io_in_deqReady      (io_in_deqReady),
        .io_out_count        (io_out_count),
        .io_out_flushDropCnt (io_out_flushDropCnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        fl;
        logic        v;
        logic [31:0] pc;
        logic        dq;
        logic        ev;
        logic        er;
        logic [2:0]  ec;
        logic [31:0] epc;
        logic [31:0] einst;
        logic [7:0]  ed;
    } vec_t;

    vec_t vt [14];

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc - 32'hED;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic v, input logic [31:0] pc, input logic dq);
        @(negedge clock);
        io_in_flush    = fl;
        io_in_valid    = v;
        io_in_pc       = pc;
        io_in_inst     = inst_of(pc);
        io_in_deqReady = dq;
        #1;
    endtask

    logic [31:0] q [$];
    logic [31:0] next_pc;
    int          exp_drop;

    initial begin
        reset = 1'b0;
        io_in_flush = 0; io_in_valid = 0; io_in_pc = 0; io_in_inst = 0; io_in_deqReady = 0;

        //            fl v  pc           dq  ev er ec  epc          einst      ed
        vt[0]  = '{1'b0,1'b0,32'h0,   1'b0,1'b0,1'b1,3'd0,32'h0,  32'h0, 8'd0};
        vt[1]  = '{1'b0,1'b1,32'h100, 1'b0,1'b0,1'b1,3'd0,32'h0,  32'h0, 8'd0};
        vt[2]  = '{1'b0,1'b0,32'h0,   1'b0,1'b1,1'b1,3'd1,32'h100,32'h13,8'd0};
        vt[3]  = '{1'b0,1'b1,32'h104, 1'b0,1'b1,1'b1,3'd1,32'h100,32'h13,8'd0};
        vt[4]  = '{1'b0,1'b1,32'h108, 1'b0,1'b1,1'b1,3'd2,32'h100,32'h13,8'd0};
        vt[5]  = '{1'b0,1'b1,32'h10C, 1'b0,1'b1,1'b1,3'd3,32'h100,32'h13,8'd0};
        vt[6]  = '{1'b0,1'b1,32'h110, 1'b0,1'b1,1'b0,3'd4,32'h100,32'h13,8'd0};
        vt[7]  = '{1'b0,1'b1,32'h110, 1'b0,1'b1,1'b0,3'd4,32'h100,32'h13,8'd0};
        vt[8]  = '{1'b0,1'b1,32'h110, 1'b1,1'b1,1'b0,3'd4,32'h100,32'h13,8'd0};
        vt[9]  = '{1'b0,1'b1,32'h110, 1'b0,1'b1,1'b1,3'd3,32'h104,32'h17,8'd0};
        vt[10] = '{1'b0,1'b0,32'h0,   1'b1,1'b1,1'b0,3'd4,32'h104,32'h17,8'd0};
        vt[11] = '{1'b0,1'b0,32'h0,   1'b1,1'b1,1'b1,3'd3,32'h108,32'h1B,8'd0};
        vt[12] = '{1'b0,1'b0,32'h0,   1'b1,1'b1,1'b1,3'd2,32'h10C,32'h1F,8'd0};
        vt[13] = '{1'b0,1'b0,32'h0,   1'b0,1'b1,1'b1,3'd1,32'h110,32'h23,8'd0};

        // Reset held
        repeat (2) @(posedge clock);
        #1;
        chk("rst.valid", 64'(io_out_valid), 64'd0);
        chk("rst.ready", 64'(io_in_ready), 64'd1);
        chk("rst.count", 64'(io_out_count), 64'd0);
        chk("rst.drop",  64'(io_out_flushDropCnt), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Table: enqueue, fill, full refusal, deq-on-full, drain
        for (int i = 0; i < 14; i++) begin
            drive(vt[i].fl, vt[i].v, vt[i].pc, vt[i].dq);
            chk($sformatf("vec%0d.valid", i), 64'(io_out_valid), 64'(vt[i].ev));
            chk($sformatf("vec%0d.ready", i), 64'(io_in_ready), 64'(vt[i].er));
            chk($sformatf("vec%0d.count", i), 64'(io_out_count), 64'(vt[i].ec));
            chk($sformatf("vec%0d.pc", i),    64'(io_out_pc), 64'(vt[i].epc));
            chk($sformatf("vec%0d.inst", i),  64'(io_out_inst), 64'(vt[i].einst));
            chk($sformatf("vec%0d.drop", i),  64'(io_out_flushDropCnt), 64'(vt[i].ed));
        end

        // Steady enq+deq at count 2 across pointer wrap
        q.push_back(32'h110);
        next_pc = 32'h114;
        drive(0, 1, next_pc, 0);
        chk("wrap.pre_count", 64'(io_out_count), 64'd1);
        q.push_back(next_pc);
        next_pc += 4;
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, next_pc, 1);
            chk($sformatf("wrap%0d.valid", i), 64'(io_out_valid), 64'd1);
            chk($sformatf("wrap%0d.ready", i), 64'(io_in_ready), 64'd1);
            chk($sformatf("wrap%0d.count", i), 64'(io_out_count), 64'd2);
            chk($sformatf("wrap%0d.pc", i),    64'(io_out_pc), 64'(q[0]));
            chk($sformatf("wrap%0d.inst", i),  64'(io_out_inst), 64'(inst_of(q[0])));
            void'(q.pop_front());
            q.push_back(next_pc);
            next_pc += 4;
        end

        // Flush with count 3, valid and deqReady high
        drive(0, 1, next_pc, 0);
        chk("fl.pre_count", 64'(io_out_count), 64'd2);
        next_pc += 4;
        drive(1, 1, next_pc, 1);
        chk("fl.valid", 64'(io_out_valid), 64'd0);
        chk("fl.ready", 64'(io_in_ready), 64'd0);
        chk("fl.count", 64'(io_out_count), 64'd3);
        drive(0, 0, 0, 0);
        chk("fl.post_count", 64'(io_out_count), 64'd0);
        chk("fl.post_drop",  64'(io_out_flushDropCnt), 64'd1);
        chk("fl.post_valid", 64'(io_out_valid), 64'd0);
        chk("fl.post_ready", 64'(io_in_ready), 64'd1);
        chk("fl.post_pc",    64'(io_out_pc), 64'd0);
        q.delete();
        drive(1, 0, 0, 0);
        chk("fle.ready", 64'(io_in_ready), 64'd0);
        drive(1, 1, 32'h200, 0);
        chk("fle.held_valid", 64'(io_out_valid), 64'd0);
        drive(0, 0, 0, 0);
        chk("fle.drop",  64'(io_out_flushDropCnt), 64'd1);
        chk("fle.count", 64'(io_out_count), 64'd0);

        // Saturation of the drop counter
        exp_drop = 1;
        for (int i = 0; i < 300; i++) begin
            drive(0, 1, 32'h300, 0);
            chk($sformatf("sat%0d.drop", i), 64'(io_out_flushDropCnt), 64'(exp_drop));
            drive(1, 0, 0, 0);
            chk($sformatf("sat%0d.count", i), 64'(io_out_count), 64'd1);
            if (exp_drop < 255) exp_drop++;
        end
        drive(0, 0, 0, 0);
        chk("sat.final", 64'(io_out_flushDropCnt), 64'd255);

        // Asynchronous reset mid-stream with count 3
        drive(0, 1, 32'h400, 0);
        drive(0, 1, 32'h404, 0);
        drive(0, 1, 32'h408, 0);
        drive(0, 1, 32'h40C, 1);
        chk("arst.pre_count", 64'(io_out_count), 64'd3);
        #1;
        reset = 1'b0;
        #1;
        chk("arst.count", 64'(io_out_count), 64'd0);
        chk("arst.valid", 64'(io_out_valid), 64'd0);
        chk("arst.ready", 64'(io_in_ready), 64'd1);
        chk("arst.drop",  64'(io_out_flushDropCnt), 64'd0);
        @(negedge clock);
        io_in_valid = 0; io_in_deqReady = 0;
        reset = 1'b1;
        drive(0, 0, 0, 0);
        chk("arst.after_count", 64'(io_out_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
